// File: rtl/note_step_sequencer.sv
// rtl/note_step_sequencer.sv - timed step sequencer playing a note ROM as note-on/note-off events
//
// Walks a 2^N-entry note ROM (1-cycle read latency) in up, down or ping-pong
// order. Each step lasts step_ticks cycles. A note-on is emitted at the start
// of the step, and the matching note-off is emitted gate_ticks cycles after
// the step strobe. Events leave on a valid/ready handshake.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   start, stop            single-cycle control pulses
//   mode                   0=up 1=down 2=ping-pong 3=up (sampled on start)
//   step_ticks, gate_ticks step period / gate length (sampled at step start)
//   rom_index              ROM address
//   rom_note, rom_velocity ROM read data, valid one cycle after rom_index
//   ev_valid, ev_ready     event handshake
//   ev_type                1=note-on, 0=note-off
//   ev_note, ev_velocity   event payload (velocity 0 on note-off)
//   playing                high while not idle
//   step_strobe            one-cycle pulse at each step start
module note_step_sequencer #(
  parameter int N  = 3,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    mode,
  input  logic [TW-1:0] step_ticks,
  input  logic [TW-1:0] gate_ticks,
  output logic [N-1:0]  rom_index,
  input  logic [7:0]    rom_note,
  input  logic [7:0]    rom_velocity,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic          ev_type,
  output logic [7:0]    ev_note,
  output logic [7:0]    ev_velocity,
  output logic          playing,
  output logic          step_strobe
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ON, GATE, OFF, WAIT} state_t;
  state_t state, state_nx;

  localparam logic [N-1:0] IDX_MAX = '1;

  logic [N-1:0]  idx, idx_nx;
  logic          dir, dir_nx;      // ping-pong direction, 1 = descending
  logic [1:0]    mode_r;
  logic [TW-1:0] cnt, sp, gt;
  logic [7:0]    note_r, vel_r;
  logic          stop_pend;
  logic          stop_any;
  logic [TW-1:0] sp_m1, gate_lim;
  logic [TW:0]   cnt_p1;

  assign stop_any  = stop | stop_pend;
  assign sp_m1     = (sp == '0) ? '0 : sp - TW'(1);   // sp==0 behaves as 1
  assign gate_lim  = (gt < sp_m1) ? gt : sp_m1;
  // GATE looks one count ahead so the note-off is presented exactly when
  // cnt reaches the gate limit.
  assign cnt_p1    = {1'b0, cnt} + (TW+1)'(1);
  assign rom_index = idx;

  // Next index for the current traversal mode.
  always_comb begin
    idx_nx = idx;
    dir_nx = dir;
    case (mode_r)
      2'd1: idx_nx = idx - N'(1);
      2'd2: begin
        if (!dir) begin
          if (idx == IDX_MAX) begin
            idx_nx = idx - N'(1);
            dir_nx = 1'b1;
          end else begin
            idx_nx = idx + N'(1);
          end
        end else begin
          if (idx == '0) begin
            idx_nx = idx + N'(1);
            dir_nx = 1'b0;
          end else begin
            idx_nx = idx - N'(1);
          end
        end
      end
      default: idx_nx = idx + N'(1);
    endcase
  end

  always_comb begin
    state_nx    = state;
    ev_valid    = 1'b0;
    ev_type     = 1'b0;
    ev_note     = 8'd0;
    ev_velocity = 8'd0;
    step_strobe = 1'b0;
    playing     = (state != IDLE);
    case (state)
      IDLE:  if (start && !stop) state_nx = FETCH;
      FETCH: begin
        step_strobe = 1'b1;
        state_nx    = stop_any ? IDLE : LOAD;
      end
      LOAD: begin
        if (stop_any)                             state_nx = IDLE;
        else if (gt == '0 || rom_velocity == '0)  state_nx = WAIT;   // rest step
        else                                      state_nx = ON;
      end
      ON: begin
        ev_valid    = 1'b1;
        ev_type     = 1'b1;
        ev_note     = note_r;
        ev_velocity = vel_r;
        // A note-on already offered is never withdrawn; stop only skips GATE.
        if (ev_ready) state_nx = stop_any ? OFF : GATE;
      end
      GATE:  if (stop_any || cnt_p1 >= {1'b0, gate_lim}) state_nx = OFF;
      OFF: begin
        ev_valid = 1'b1;
        ev_note  = note_r;
        if (ev_ready) state_nx = stop_any ? IDLE : WAIT;
      end
      WAIT: begin
        if (stop_any)           state_nx = IDLE;
        else if (cnt >= sp_m1)  state_nx = FETCH;   // also covers stretched steps
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      dir       <= 1'b0;
      mode_r    <= 2'd0;
      cnt       <= '0;
      sp        <= '0;
      gt        <= '0;
      note_r    <= 8'd0;
      vel_r     <= 8'd0;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_nx;
      stop_pend <= (state == IDLE) ? 1'b0 : (stop_pend | stop);

      if (state_nx == FETCH || state_nx == IDLE) cnt <= '0;
      else if (cnt != '1)                        cnt <= cnt + TW'(1);

      if (state == IDLE && state_nx == FETCH) begin
        mode_r <= mode;
        dir    <= 1'b0;
        idx    <= (mode == 2'd1) ? IDX_MAX : '0;
      end else if (state == WAIT && state_nx == FETCH) begin
        idx <= idx_nx;
        dir <= dir_nx;
      end

      if (state == FETCH) begin
        sp <= step_ticks;
        gt <= gate_ticks;
      end

      if (state == LOAD) begin
        note_r <= rom_note;
        vel_r  <= rom_velocity;
      end
    end
  end

endmodule

// File: tb/tb_note_step_sequencer.sv
// tb/tb_note_step_sequencer.sv - self-checking bench for note_step_sequencer
module tb_note_step_sequencer;
  localparam int N  = 3;
  localparam int TW = 16;
  localparam int L  = 8;

  logic          clk = 1'b0;
  logic          reset, start, stop, ev_ready;
  logic [1:0]    mode;
  logic [TW-1:0] step_ticks, gate_ticks;
  logic [N-1:0]  rom_index;
  logic [7:0]    rom_note, rom_velocity;
  logic          ev_valid, ev_type, playing, step_strobe;
  logic [7:0]    ev_note, ev_velocity;

  note_step_sequencer #(.N(N), .TW(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .step_ticks(step_ticks), .gate_ticks(gate_ticks), .rom_index(rom_index),
    .rom_note(rom_note), .rom_velocity(rom_velocity), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_type(ev_type), .ev_note(ev_note),
    .ev_velocity(ev_velocity), .playing(playing), .step_strobe(step_strobe)
  );

  always #5 clk = ~clk;

  logic [7:0] rom_n [L] = '{8'd60, 8'd62, 8'd64, 8'd65, 8'd67, 8'd69, 8'd71, 8'd72};
  logic [7:0] rom_v [L] = '{8'd100, 8'd80, 8'd70, 8'd60, 8'd50, 8'd0, 8'd40, 8'd30};

  always @(posedge clk) begin
    rom_note     <= rom_n[rom_index];
    rom_velocity <= rom_v[rom_index];
  end

  typedef struct { int cyc; logic typ; logic [7:0] note; logic [7:0] vel; } ev_t;
  typedef struct { int cyc; logic [N-1:0] idx; } st_t;
  ev_t obs_q[$];
  st_t str_q[$];
  ev_t exp_q[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int proto_err = 0;
  logic rnd_ready = 1'b0;
  logic pv = 1'b0, pr = 1'b0, pt = 1'b0;
  logic [7:0] pn = 8'd0, pvl = 8'd0;

  always @(posedge clk) cyc++;

  // Event/strobe recorder and handshake stability monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (pv && !pr && (!ev_valid || ev_type != pt || ev_note != pn || ev_velocity != pvl))
        proto_err++;
      if (ev_valid && ev_ready) obs_q.push_back('{cyc, ev_type, ev_note, ev_velocity});
      if (step_strobe) str_q.push_back('{cyc, rom_index});
    end
    pv = ev_valid && !reset; pr = ev_ready; pt = ev_type; pn = ev_note; pvl = ev_velocity;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      if (rnd_ready) ev_ready = ($urandom_range(3) != 0);
    end
  endtask

  task automatic do_reset();
    rnd_ready = 1'b0; reset = 1'b1; start = 1'b0; stop = 1'b0; ev_ready = 1'b1;
    mode = 2'd0; step_ticks = '0; gate_ticks = '0;
    tick(2); reset = 1'b0; tick(1);
    obs_q.delete(); str_q.delete();
  endtask

  task automatic pulse_start(); start = 1'b1; tick(1); start = 1'b0; endtask
  task automatic pulse_stop();  stop  = 1'b1; tick(1); stop  = 1'b0; endtask

  task automatic stop_and_idle(input string name);
    pulse_stop();
    for (int t = 0; t < 300 && playing; t++) tick(1);
    check(name, playing, 0);
  endtask

  // Reference traversal: k-th visited index for a mode.
  function automatic int model_idx(input int m, input int k);
    int p;
    case (m)
      1: return L - 1 - (k % L);
      2: begin
        p = k % (2 * L - 2);
        return (p < L) ? p : 2 * L - 2 - p;
      end
      default: return k % L;
    endcase
  endfunction

  typedef struct { logic [1:0] m; int sp; int gt; int period; int off_dly; logic [47:0] seq; } vec_t;
  vec_t vecs[4];

  initial begin
    int n, sp_r, gt_r, m_r, c_s, bad, offk;

    vecs[0] = '{2'd0, 10, 5, 10, 5, 48'o7654321076543210};
    vecs[1] = '{2'd2,  6, 2,  6, 4, 48'o1012345676543210};
    vecs[2] = '{2'd1,  8, 3,  8, 4, 48'o0123456701234567};
    vecs[3] = '{2'd3, 12, 7, 12, 7, 48'o7654321076543210};

    // Reset state, sampled while reset is held.
    reset = 1'b1; start = 1'b0; stop = 1'b0; ev_ready = 1'b1;
    mode = 2'd0; step_ticks = '0; gate_ticks = '0;
    tick(2);
    check("reset_outputs", {29'd0, rom_index, ev_valid, ev_type, ev_note, ev_velocity, playing, step_strobe}, 0);
    do_reset();

    // Table-driven traversal, step period and gate length.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      mode = vecs[v].m; step_ticks = TW'(vecs[v].sp); gate_ticks = TW'(vecs[v].gt);
      pulse_start();
      for (int t = 0; t < 16 * vecs[v].sp + 40 && str_q.size() < 16; t++) tick(1);
      check($sformatf("v%0d_strobe_count", v), str_q.size() >= 16, 1);
      for (int k = 0; k < 16 && k < str_q.size(); k++)
        check($sformatf("v%0d_idx%0d", v, k), str_q[k].idx, vecs[v].seq[3*k +: 3]);
      for (int k = 1; k < 16 && k < str_q.size(); k++)
        check($sformatf("v%0d_period%0d", v, k), str_q[k].cyc - str_q[k-1].cyc, vecs[v].period);
      offk = -1;
      for (int k = 0; k < obs_q.size() && offk < 0; k++) if (!obs_q[k].typ) offk = k;
      check($sformatf("v%0d_off_delay", v),
            (offk >= 0 && str_q.size() > 0) ? obs_q[offk].cyc - str_q[0].cyc : -1, vecs[v].off_dly);
      stop_and_idle($sformatf("v%0d_idle", v));
    end

    // Basic up sweep: first events and their timing.
    do_reset();
    mode = 2'd0; step_ticks = 10; gate_ticks = 5;
    pulse_start();
    for (int t = 0; t < 60 && obs_q.size() < 3; t++) tick(1);
    check("basic_ev_count", obs_q.size() >= 3 && str_q.size() >= 2, 1);
    if (obs_q.size() >= 3 && str_q.size() >= 2) begin
      check("basic_on_type", obs_q[0].typ, 1);
      check("basic_on_note", obs_q[0].note, 60);
      check("basic_on_vel", obs_q[0].vel, 100);
      check("basic_off_type", obs_q[1].typ, 0);
      check("basic_off_note", obs_q[1].note, 60);
      check("basic_off_vel", obs_q[1].vel, 0);
      check("basic_off_delay", obs_q[1].cyc - str_q[0].cyc, 5);
      check("basic_on2_note", obs_q[2].note, 62);
      check("basic_on2_vel", obs_q[2].vel, 80);
      check("basic_step_gap", str_q[1].cyc - str_q[0].cyc, 10);
    end
    stop_and_idle("basic_idle");

    // Backpressure on the first note-on.
    do_reset();
    mode = 2'd0; step_ticks = 8; gate_ticks = 3; ev_ready = 1'b0;
    pulse_start();
    for (int t = 0; t < 20 && !ev_valid; t++) tick(1);
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      if (!(ev_valid && ev_type && ev_note == 8'd60 && ev_velocity == 8'd100)) bad++;
      tick(1);
    end
    check("bp_stable_cycles_bad", bad, 0);
    ev_ready = 1'b1;
    for (int t = 0; t < 40 && str_q.size() < 2; t++) tick(1);
    check("bp_ev_count", obs_q.size() >= 2 && str_q.size() >= 2, 1);
    if (obs_q.size() >= 2 && str_q.size() >= 2) begin
      check("bp_off_type", obs_q[1].typ, 0);
      check("bp_off_note", obs_q[1].note, 60);
      check("bp_strobe_after_off", str_q[1].cyc - obs_q[1].cyc, 2);
    end
    check("bp_protocol", proto_err, 0);
    stop_and_idle("bp_idle");

    // Stop during GATE.
    do_reset();
    mode = 2'd0; step_ticks = 60; gate_ticks = 50;
    pulse_start();
    for (int t = 0; t < 20 && obs_q.size() < 1; t++) tick(1);
    tick(1);
    c_s = cyc;
    pulse_stop();
    for (int t = 0; t < 4 && obs_q.size() < 2; t++) tick(1);
    check("sg_off_seen", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      check("sg_off_type", obs_q[1].typ, 0);
      check("sg_off_note", obs_q[1].note, 60);
      check("sg_off_within2", (obs_q[1].cyc - c_s) <= 2, 1);
    end
    tick(2);
    check("sg_playing", playing, 0);
    tick(30);
    check("sg_no_more_events", obs_q.size(), 2);

    // Stop while the note-on is stalled.
    do_reset();
    mode = 2'd0; step_ticks = 8; gate_ticks = 3; ev_ready = 1'b0;
    pulse_start();
    for (int t = 0; t < 20 && !ev_valid; t++) tick(1);
    tick(3);
    pulse_stop();
    tick(4);
    check("ss_on_held", {ev_valid, ev_type}, 2'b11);
    ev_ready = 1'b1;
    for (int t = 0; t < 20 && playing; t++) tick(1);
    check("ss_playing", playing, 0);
    check("ss_ev_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("ss_on", {obs_q[0].typ, obs_q[0].note}, {1'b1, 8'd60});
      check("ss_off", {obs_q[1].typ, obs_q[1].note, obs_q[1].vel}, {1'b0, 8'd60, 8'd0});
    end

    // Rest steps: gate_ticks=0.
    do_reset();
    mode = 2'd0; step_ticks = 8; gate_ticks = 0;
    pulse_start();
    tick(40);
    check("rest_no_events", obs_q.size(), 0);
    check("rest_strobes", str_q.size(), 5);
    stop_and_idle("rest_idle");

    // start and stop together in IDLE.
    do_reset();
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    tick(3);
    check("ss_same_cycle_playing", playing, 0);
    check("ss_same_cycle_strobes", str_q.size(), 0);

    // Asynchronous reset in GATE (down mode so rom_index is non-zero).
    do_reset();
    mode = 2'd1; step_ticks = 60; gate_ticks = 50;
    pulse_start();
    for (int t = 0; t < 20 && obs_q.size() < 1; t++) tick(1);
    tick(2);
    check("ar_before", {playing, rom_index}, {1'b1, 3'd7});
    #2 reset = 1'b1;
    #1 check("ar_outputs_zero", {29'd0, rom_index, ev_valid, ev_type, ev_note, ev_velocity, playing, step_strobe}, 0);
    tick(1);
    reset = 1'b0;

    // Randomized runs against the reference model.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      m_r = $urandom_range(3); sp_r = $urandom_range(12, 0); gt_r = $urandom_range(10, 0);
      mode = m_r[1:0]; step_ticks = TW'(sp_r); gate_ticks = TW'(gt_r);
      rnd_ready = 1'b1;
      pulse_start();
      for (int t = 0; t < 3000 && str_q.size() < 12; t++) tick(1);
      check($sformatf("r%0d_strobes", r), str_q.size() >= 12, 1);
      tick($urandom_range(12, 0));
      stop_and_idle($sformatf("r%0d_idle", r));
      rnd_ready = 1'b0; ev_ready = 1'b1;
      exp_q.delete();
      for (int k = 0; k < str_q.size(); k++) begin
        n = model_idx(m_r, k);
        check($sformatf("r%0d_idx%0d", r, k), str_q[k].idx, n);
        if (gt_r != 0 && rom_v[n] != 0) begin
          exp_q.push_back('{0, 1'b1, rom_n[n], rom_v[n]});
          exp_q.push_back('{0, 1'b0, rom_n[n], 8'd0});
        end
      end
      n = obs_q.size();
      check($sformatf("r%0d_ev_pairs", r), n % 2, 0);
      check($sformatf("r%0d_ev_count", r), (n <= exp_q.size()) && (n + 2 >= exp_q.size()), 1);
      for (int k = 0; k < n && k < exp_q.size(); k++)
        check($sformatf("r%0d_ev%0d", r, k), {obs_q[k].typ, obs_q[k].note, obs_q[k].vel},
              {exp_q[k].typ, exp_q[k].note, exp_q[k].vel});
    end
    check("protocol_total", proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
